// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Arbitrates the ALU and load write-back paths onto the single
//            register-file write port, with registered write outputs.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int PRIORITY_MEM = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        write_enable,
    output logic [4:0]  address_d,
    output logic [31:0] data_dval,
    output logic [3:0]  alu_starve_cnt
);

    localparam logic       c_grant_alu    = 1'b0;
    localparam logic       c_grant_mem    = 1'b1;
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic        r_last_grant;
    logic [3:0]  r_alu_starve_cnt;
    logic        r_write_enable;
    logic [4:0]  r_address_d;
    logic [31:0] r_data_dval;

    logic        w_grant_alu;
    logic        w_grant_mem;
    logic        w_xfer;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;

    // Grant depends only on the valids and internal state, never on addr/data.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!reset) begin
            if (alu_valid && !mem_valid) begin
                w_grant_alu = 1'b1;
            end else if (mem_valid && !alu_valid) begin
                w_grant_mem = 1'b1;
            end else if (alu_valid && mem_valid) begin
                if (PRIORITY_MEM != 0) begin
                    if (r_alu_starve_cnt == c_starve_limit) begin
                        w_grant_alu = 1'b1;
                    end else begin
                        w_grant_mem = 1'b1;
                    end
                end else begin
                    if (r_last_grant == c_grant_mem) begin
                        w_grant_alu = 1'b1;
                    end else begin
                        w_grant_mem = 1'b1;
                    end
                end
            end
        end
    end

    assign alu_ready  = w_grant_alu;
    assign mem_ready  = w_grant_mem;
    assign w_xfer     = w_grant_alu | w_grant_mem;
    assign w_sel_addr = w_grant_alu ? alu_addr : mem_addr;
    assign w_sel_data = w_grant_alu ? alu_data : mem_data;

    generate
        if (PRIORITY_MEM != 0) begin : g_fixed_prio
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_alu_starve_cnt <= 4'd0;
                end else if (!alu_valid || w_grant_alu) begin
                    r_alu_starve_cnt <= 4'd0;
                end else if (w_grant_mem && (r_alu_starve_cnt != c_starve_limit)) begin
                    r_alu_starve_cnt <= r_alu_starve_cnt + 4'd1;
                end
            end
        end else begin : g_round_robin
            always_ff @(posedge clock) begin
                r_alu_starve_cnt <= 4'd0;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= c_grant_mem;
        end else if (w_xfer) begin
            r_last_grant <= w_grant_alu ? c_grant_alu : c_grant_mem;
        end
    end

    // Writes to $0 are accepted but never reach the register file.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_write_enable <= 1'b0;
            r_address_d    <= 5'd0;
            r_data_dval    <= 32'd0;
        end else if (w_xfer && (w_sel_addr != 5'd0)) begin
            r_write_enable <= 1'b1;
            r_address_d    <= w_sel_addr;
            r_data_dval    <= w_sel_data;
        end else begin
            r_write_enable <= 1'b0;
        end
    end

    assign write_enable   = r_write_enable;
    assign address_d      = r_address_d;
    assign data_dval      = r_data_dval;
    assign alu_starve_cnt = r_alu_starve_cnt;

endmodule
`default_nettype wire
